// File: rtl/scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_pkg
// Description : Shared types and default widths for the sector-scan sequencer.
//               Holds the FSM state enum, default interface widths, the
//               saturation limit for the stepped angle and the watchdog limit.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_pkg;

    localparam int DEF_ANGLE_DW       = 8;
    localparam int DEF_DW_INPUT       = 8;
    localparam int DEF_NPTS_DW        = 13;
    localparam int DEF_LINE_DW        = 8;
    localparam int DEF_PRI_DW         = 16;
    localparam int DEF_ANGLE_MAX      = 180;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        DEAD      = 3'd3,
        FRAME_END = 3'd4,
        ERROR     = 3'd5
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Loadable down-counter shared between the dead-time delay and
//               the done watchdog (the two users are never active together).
//               expired is high in the cycle where the loaded count has been
//               consumed, i.e. the last of load_value enabled cycles.
// Ports       : clk, rst        - clock, async active-high reset
//               load            - reload count with load_value (wins over enable)
//               load_value      - reload value
//               enable          - count down this cycle
//               expired         - count has reached its final cycle
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    // A count of 1 means this is the last counted cycle, so the owner can
    // leave its state on this edge and spend exactly load_value cycles there.
    assign expired = (r_count <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scan_sequencer
// Description : Frame controller driving the Transmitter through a sector
//               scan: one initiate per line, wait for done, programmable
//               dead time, saturating angle step, watchdog on done.
// Ports       : clk, rst                 - clock, async active-high reset
//               start, abort             - frame control pulses
//               cfg_*                    - frame configuration (latched on start)
//               tx_initiate/r_0/angle/num_points - Transmitter command outputs
//               tx_done                  - Transmitter line-complete pulse
//               busy, line_idx           - frame status
//               frame_done, err_timeout  - completion pulse, sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int ANGLE_DW       = DEF_ANGLE_DW,
    parameter int DW_INPUT       = DEF_DW_INPUT,
    parameter int NPTS_DW        = DEF_NPTS_DW,
    parameter int LINE_DW        = DEF_LINE_DW,
    parameter int PRI_DW         = DEF_PRI_DW,
    parameter int ANGLE_MAX      = DEF_ANGLE_MAX,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [ANGLE_DW-1:0] cfg_angle_start,
    input  logic [ANGLE_DW-1:0] cfg_angle_step,
    input  logic [LINE_DW-1:0]  cfg_num_lines,
    input  logic [DW_INPUT-1:0] cfg_r_0,
    input  logic [NPTS_DW-1:0]  cfg_num_points,
    input  logic [PRI_DW-1:0]   cfg_pri_cycles,
    output logic                tx_initiate,
    output logic [DW_INPUT-1:0] tx_r_0,
    output logic [ANGLE_DW-1:0] tx_angle,
    output logic [NPTS_DW-1:0]  tx_num_points,
    input  logic                tx_done,
    output logic                busy,
    output logic [LINE_DW-1:0]  line_idx,
    output logic                frame_done,
    output logic                err_timeout
);

    // The shared timer is PRI_DW wide; the watchdog limit must fit in it.
    localparam logic [PRI_DW-1:0]   c_timeout_val   = PRI_DW'(TIMEOUT_CYCLES);
    localparam logic [ANGLE_DW:0]   c_angle_max_ext = (ANGLE_DW + 1)'(ANGLE_MAX);
    localparam logic [ANGLE_DW-1:0] c_angle_max     = ANGLE_DW'(ANGLE_MAX);

    scan_state_t         r_state;
    scan_state_t         w_state_next;
    logic [LINE_DW-1:0]  r_num_lines;
    logic [ANGLE_DW-1:0] r_angle_step;
    logic [PRI_DW-1:0]   r_pri_cycles;
    logic [LINE_DW-1:0]  r_line_idx;
    logic                r_err;

    logic                w_timer_load;
    logic [PRI_DW-1:0]   w_timer_value;
    logic                w_timer_enable;
    logic                w_timer_expired;
    logic                w_last_line;
    logic                w_accept;
    logic                w_advance;
    logic [ANGLE_DW:0]   w_angle_sum;
    logic [ANGLE_DW-1:0] w_angle_next;

    scan_timer #(
        .WIDTH (PRI_DW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_timer_load),
        .load_value (w_timer_value),
        .enable     (w_timer_enable),
        .expired    (w_timer_expired)
    );

    assign w_last_line    = (r_line_idx == (r_num_lines - LINE_DW'(1)));
    assign w_timer_enable = (r_state == WAIT_DONE) || (r_state == DEAD);

    // One extra bit catches the carry so an overflowing step saturates
    // instead of wrapping; once at the limit every further step stays there.
    assign w_angle_sum  = {1'b0, tx_angle} + {1'b0, r_angle_step};
    assign w_angle_next = (w_angle_sum > c_angle_max_ext) ? c_angle_max
                                                          : w_angle_sum[ANGLE_DW-1:0];

    always_comb begin
        w_state_next  = r_state;
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        case (r_state)
            IDLE: begin
                if (start && !abort && (cfg_num_lines != '0)) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                w_state_next  = WAIT_DONE;
                w_timer_load  = 1'b1;
                w_timer_value = c_timeout_val;
            end
            WAIT_DONE: begin
                // done is checked first so it wins over a same-cycle timeout
                if (tx_done) begin
                    if (w_last_line) begin
                        w_state_next = FRAME_END;
                    end else if (r_pri_cycles == '0) begin
                        w_state_next = ISSUE;
                    end else begin
                        w_state_next  = DEAD;
                        w_timer_load  = 1'b1;
                        w_timer_value = r_pri_cycles;
                    end
                end else if (w_timer_expired) begin
                    w_state_next = ERROR;
                end
            end
            DEAD: begin
                if (w_timer_expired) begin
                    w_state_next = ISSUE;
                end
            end
            FRAME_END: w_state_next = IDLE;
            ERROR:     w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_state_next = IDLE;
        end
    end

    assign w_accept  = (r_state == IDLE) && (w_state_next == ISSUE);
    assign w_advance = ((r_state == WAIT_DONE) || (r_state == DEAD)) && (w_state_next == ISSUE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_num_lines   <= '0;
            r_angle_step  <= '0;
            r_pri_cycles  <= '0;
            r_line_idx    <= '0;
            r_err         <= 1'b0;
            tx_r_0        <= '0;
            tx_angle      <= '0;
            tx_num_points <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_num_lines   <= cfg_num_lines;
                r_angle_step  <= cfg_angle_step;
                r_pri_cycles  <= cfg_pri_cycles;
                r_line_idx    <= '0;
                r_err         <= 1'b0;
                tx_r_0        <= cfg_r_0;
                tx_num_points <= cfg_num_points;
                tx_angle      <= cfg_angle_start;
            end else if (w_advance) begin
                r_line_idx <= r_line_idx + LINE_DW'(1);
                tx_angle   <= w_angle_next;
            end
            if (w_state_next == ERROR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign tx_initiate = (r_state == ISSUE);
    assign frame_done  = (r_state == FRAME_END);
    assign busy        = (r_state != IDLE);
    assign line_idx    = r_line_idx;
    assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_scan_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_scan_sequencer
// Description : Directed self-checking bench for scan_sequencer with a simple
//               Transmitter model returning done a set delay after initiate.
//               Cycle numbers are relative to the cycle in which start is
//               driven (cycle 0); DUT outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  cfg_angle_start = '0;
    logic [7:0]  cfg_angle_step = '0;
    logic [7:0]  cfg_num_lines = '0;
    logic [7:0]  cfg_r_0 = '0;
    logic [12:0] cfg_num_points = '0;
    logic [15:0] cfg_pri_cycles = '0;
    logic        tx_initiate;
    logic [7:0]  tx_r_0;
    logic [7:0]  tx_angle;
    logic [12:0] tx_num_points;
    logic        tx_done;
    logic        busy;
    logic [7:0]  line_idx;
    logic        frame_done;
    logic        err_timeout;

    logic model_done = 1'b0;
    logic stray_done = 1'b0;
    assign tx_done = model_done | stray_done;

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int t0 = 0;
    int tx_delay = 0;
    int tx_cnt = 0;
    int init_cyc[$];
    int init_ang[$];
    int fd_cyc[$];

    scan_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_angle_start (cfg_angle_start),
        .cfg_angle_step  (cfg_angle_step),
        .cfg_num_lines   (cfg_num_lines),
        .cfg_r_0         (cfg_r_0),
        .cfg_num_points  (cfg_num_points),
        .cfg_pri_cycles  (cfg_pri_cycles),
        .tx_initiate     (tx_initiate),
        .tx_r_0          (tx_r_0),
        .tx_angle        (tx_angle),
        .tx_num_points   (tx_num_points),
        .tx_done         (tx_done),
        .busy            (busy),
        .line_idx        (line_idx),
        .frame_done      (frame_done),
        .err_timeout     (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    // Transmitter model and event recorder (tx_delay <= 0: never answers)
    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) begin
            tx_cnt = 0;
        end else begin
            if (tx_cnt > 0) begin
                tx_cnt--;
                if (tx_cnt == 0) model_done = 1'b1;
            end
            if (tx_initiate && (tx_delay > 0)) tx_cnt = tx_delay;
        end
        if (tx_initiate) begin
            init_cyc.push_back(ncyc);
            init_ang.push_back(int'(tx_angle));
        end
        if (frame_done) fd_cyc.push_back(ncyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start(input int a0, input int st, input int nl, input int r0,
                            input int np, input int pri);
        cfg_angle_start = 8'(a0);
        cfg_angle_step  = 8'(st);
        cfg_num_lines   = 8'(nl);
        cfg_r_0         = 8'(r0);
        cfg_num_points  = 13'(np);
        cfg_pri_cycles  = 16'(pri);
        start = 1'b1;
        t0 = ncyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, output int rel);
        int n;
        n = 0;
        while ((busy !== 1'b0) && (n < max_cyc)) begin
            tick();
            n++;
        end
        rel = ncyc - t0;
        chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic go_to(input int rel);
        while ((ncyc - t0) < rel) tick();
    endtask

    initial begin
        int b;
        int f;
        int rel;
        int exp_nom[5];
        int exp_sat[4];
        exp_nom = '{50, 70, 90, 110, 130};
        exp_sat = '{150, 170, 180, 180};

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_initiate", {31'd0, tx_initiate}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_angle", {24'd0, tx_angle}, 0);
        chk("rst_r0", {24'd0, tx_r_0}, 0);
        chk("rst_npts", {19'd0, tx_num_points}, 0);
        chk("rst_line", {24'd0, line_idx}, 0);
        chk("rst_fd_err", {30'd0, frame_done, err_timeout}, 0);
        rst = 1'b0;
        tick();

        // ---------------- nominal frame ----------------
        tx_delay = 40;
        b = init_cyc.size();
        f = fd_cyc.size();
        do_start(50, 20, 5, 30, 3, 10);
        // configuration changes while busy must not take effect
        cfg_r_0 = 8'd99;
        cfg_angle_step = 8'd1;
        cfg_num_lines = 8'd2;
        chk("nom_init_c1", {31'd0, tx_initiate}, 1);
        chk("nom_angle_c1", {24'd0, tx_angle}, 50);
        chk("nom_r0_c1", {24'd0, tx_r_0}, 30);
        chk("nom_npts_c1", {19'd0, tx_num_points}, 3);
        tick();
        chk("nom_init_pulse", {31'd0, tx_initiate}, 0);
        wait_idle(1000, rel);
        chk("nom_idle_cycle", rel, 247);
        chk("nom_ninit", init_cyc.size() - b, 5);
        chk("nom_first_cyc", init_cyc[b] - t0, 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("nom_angle%0d", i), init_ang[b + i], exp_nom[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("nom_space%0d", i), init_cyc[b + i + 1] - init_cyc[b + i], 51);
        end
        chk("nom_nfd", fd_cyc.size() - f, 1);
        chk("nom_fd_cyc", fd_cyc[f] - t0, 246);
        chk("nom_r0_held", {24'd0, tx_r_0}, 30);
        chk("nom_line_last", {24'd0, line_idx}, 4);
        chk("nom_err", {31'd0, err_timeout}, 0);

        // ---------------- angle saturation ----------------
        tx_delay = 3;
        tick();
        b = init_cyc.size();
        do_start(150, 20, 4, 1, 1, 2);
        wait_idle(500, rel);
        chk("sat_ninit", init_cyc.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat_angle%0d", i), init_ang[b + i], exp_sat[i]);
        end

        // ---------------- pri = 0, immediate done ----------------
        tx_delay = 1;
        tick();
        b = init_cyc.size();
        f = fd_cyc.size();
        do_start(10, 5, 3, 7, 9, 0);
        wait_idle(100, rel);
        chk("pri0_ninit", init_cyc.size() - b, 3);
        chk("pri0_init0", init_cyc[b] - t0, 1);
        chk("pri0_init1", init_cyc[b + 1] - t0, 3);
        chk("pri0_init2", init_cyc[b + 2] - t0, 5);
        chk("pri0_angle2", init_ang[b + 2], 20);
        chk("pri0_fd", fd_cyc[f] - t0, 7);

        // ---------------- watchdog ----------------
        tx_delay = 0;
        tick();
        b = init_cyc.size();
        f = fd_cyc.size();
        do_start(0, 1, 2, 1, 1, 0);
        go_to(4097);
        chk("wd_err_before", {31'd0, err_timeout}, 0);
        wait_idle(200, rel);
        chk("wd_idle_cycle", rel, 4099);
        chk("wd_err", {31'd0, err_timeout}, 1);
        chk("wd_ninit", init_cyc.size() - b, 1);
        chk("wd_nfd", fd_cyc.size() - f, 0);
        tick();
        chk("wd_err_sticky", {31'd0, err_timeout}, 1);
        tx_delay = 2;
        f = fd_cyc.size();
        do_start(0, 1, 1, 1, 1, 0);
        chk("wd_err_cleared", {31'd0, err_timeout}, 0);
        wait_idle(100, rel);
        chk("wd_restart_fd", fd_cyc.size() - f, 1);

        // ---------------- abort during second dead time ----------------
        tx_delay = 5;
        tick();
        b = init_cyc.size();
        f = fd_cyc.size();
        do_start(20, 10, 4, 1, 1, 10);
        go_to(25);
        chk("abt_in_dead_busy", {31'd0, busy}, 1);
        chk("abt_in_dead_line", {24'd0, line_idx}, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abt_idle", {31'd0, busy}, 0);
        repeat (30) tick();
        chk("abt_ninit", init_cyc.size() - b, 2);
        chk("abt_nfd", fd_cyc.size() - f, 0);
        chk("abt_err", {31'd0, err_timeout}, 0);

        // ---------------- abort + start together in IDLE ----------------
        b = init_cyc.size();
        abort = 1'b1;
        do_start(30, 10, 2, 1, 1, 0);
        abort = 1'b0;
        chk("abst_busy", {31'd0, busy}, 0);
        repeat (3) tick();
        chk("abst_ninit", init_cyc.size() - b, 0);

        // ---------------- stray done in IDLE ----------------
        f = fd_cyc.size();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        chk("stray_busy", {31'd0, busy}, 0);
        chk("stray_nfd", fd_cyc.size() - f, 0);

        // ---------------- reset mid-WAIT_DONE ----------------
        tx_delay = 40;
        do_start(60, 10, 3, 44, 17, 4);
        go_to(10);
        chk("rstm_busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        #1;
        chk("rstm_busy", {31'd0, busy}, 0);
        chk("rstm_angle", {24'd0, tx_angle}, 0);
        chk("rstm_r0", {24'd0, tx_r_0}, 0);
        chk("rstm_npts", {19'd0, tx_num_points}, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // ---------------- start with lines = 0 ----------------
        b = init_cyc.size();
        do_start(60, 10, 0, 44, 17, 4);
        chk("zero_busy", {31'd0, busy}, 0);
        repeat (5) tick();
        chk("zero_ninit", init_cyc.size() - b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
